is_array_ctrl: RTL and testbench

Sequencer for an ROWS×COLS input-stationary systolic array built from `processing_element_is` cells. It runs one tile in a fixed order:
- clears the array,
- preloads one activation row per cycle into the stationary registers,
- streams k_len weight vectors from the weight feeder with backpressure,
- drains the pipeline.

It sits between the tile scheduler (start/done) and the array control pins: `reg_clear`, `cell_sc_en` per row, and `pipeline_en`.

---
 rtl/is_array_ctrl.sv | 88 ++++++++
 tb/tb_is_array_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/is_array_ctrl.sv
// is_array_ctrl: tile sequencer for an input-stationary systolic array
// (clear, row-by-row activation preload, weight streaming with backpressure, drain).
module is_array_ctrl #(
    parameter int ROWS      = 4,
    parameter int COLS      = 4,
    parameter int STAGE     = 0,
    parameter int K_W       = 16,
    parameter int DRAIN_LEN = ROWS + COLS + STAGE - 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [K_W-1:0]  k_len,
    input  logic            abort,
    input  logic            wei_ready,
    output logic            reg_clear,
    output logic            act_rd,
    output logic [ROWS-1:0] act_load,
    output logic            wei_rd,
    output logic            pipeline_en,
    output logic            busy,
    output logic            done
);
    localparam int RW = ROWS > 1 ? $clog2(ROWS) : 1;
    localparam int DW = $clog2(DRAIN_LEN + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, COMPUTE, DRAIN, DONE} state_t;

    state_t          state;
    logic [K_W-1:0]  k_reg;
    logic [K_W-1:0]  issue_cnt;
    logic [RW-1:0]   row_cnt;
    logic [DW-1:0]   drain_cnt;
    logic            abort_f;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            k_reg     <= '0;
            issue_cnt <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            abort_f   <= 1'b0;
        end else if (abort && state != IDLE) begin
            abort_f   <= 1'b1;
            issue_cnt <= '0;
            row_cnt   <= '0;
            drain_cnt <= '0;
            state     <= state == CLEAR ? IDLE : CLEAR;
        end else begin
            case (state)
                IDLE: if (start) begin
                    k_reg   <= k_len;
                    abort_f <= 1'b0;
                    state   <= CLEAR;
                end
                CLEAR: begin
                    issue_cnt <= '0;
                    row_cnt   <= '0;
                    drain_cnt <= '0;
                    state     <= abort_f ? IDLE : (k_reg == '0 ? DONE : LOAD);
                end
                LOAD: begin
                    row_cnt <= row_cnt + 1'b1;
                    if (row_cnt == RW'(ROWS - 1)) state <= COMPUTE;
                end
                COMPUTE: if (wei_ready) begin
                    issue_cnt <= issue_cnt + 1'b1;
                    if (issue_cnt == k_reg - 1'b1) state <= DRAIN;
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 1'b1;
                    if (drain_cnt == DW'(DRAIN_LEN - 1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign reg_clear   = state == CLEAR;
    assign act_rd      = state == LOAD;
    assign act_load    = act_rd ? ROWS'(1) << row_cnt : '0;
    assign wei_rd      = state == COMPUTE && wei_ready;
    assign pipeline_en = wei_rd || state == DRAIN;
    assign busy        = state != IDLE;
    assign done        = state == DONE;
endmodule

// File: tb/tb_is_array_ctrl.sv
// tb_is_array_ctrl: per-cycle check of is_array_ctrl against a tile-timeline model.
module tb_is_array_ctrl;
    localparam int ROWS = 4, COLS = 4, STAGE = 1, K_W = 16, DL = 8, N = 128;
    localparam logic [9:0] CLR = 10'h200, ARD = 10'h100, WRD = 10'h008,
                           PEN = 10'h004, BSY = 10'h002, DN = 10'h001;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0, wei_ready = 1'b0;
    logic [K_W-1:0] k_len = '0;
    logic reg_clear, act_rd, wei_rd, pipeline_en, busy, done;
    logic [ROWS-1:0] act_load;

    is_array_ctrl #(.ROWS(ROWS), .COLS(COLS), .STAGE(STAGE), .K_W(K_W), .DRAIN_LEN(DL)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .k_len(k_len), .abort(abort),
        .wei_ready(wei_ready), .reg_clear(reg_clear), .act_rd(act_rd), .act_load(act_load),
        .wei_rd(wei_rd), .pipeline_en(pipeline_en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    wire [9:0] outv = {reg_clear, act_rd, act_load, wei_rd, pipeline_en, busy, done};

    int errors = 0, checks = 0;
    logic st[N], ab[N], rd[N], rn[N];
    logic [K_W-1:0] kl[N];
    logic [9:0] ex[N], obs[N];

    task automatic init();
        for (int i = 0; i < N; i++) begin
            st[i] = 1'b0; ab[i] = 1'b0; rd[i] = 1'b1; rn[i] = 1'b1;
            kl[i] = K_W'($urandom); ex[i] = '0; obs[i] = '0;
        end
    endtask

    task automatic go(int s, int k);
        st[s] = 1'b1;
        kl[s] = K_W'(k);
    endtask

    task automatic put(int c, logic [9:0] v);
        if (c >= 0 && c < N) ex[c] = v;
    endtask

    // Expected timeline of one tile started in cycle s, optionally aborted in cycle a.
    task automatic add_tile(int s, int k, int a);
        int c, iss, dn;
        put(s + 1, CLR | BSY);
        if (k == 0) dn = s + 2;
        else begin
            for (int r = 0; r < ROWS; r++) put(s + 2 + r, ARD | BSY | (10'h010 << r));
            c = s + ROWS + 2;
            iss = 0;
            while (iss < k && c < N) begin
                put(c, rd[c] ? (WRD | PEN | BSY) : BSY);
                if (rd[c]) iss++;
                c++;
            end
            for (int d = 0; d < DL; d++) put(c + d, PEN | BSY);
            dn = c + DL;
        end
        put(dn, BSY | DN);
        if (a > s && a <= dn) begin
            for (int i = a + 1; i <= dn; i++) put(i, '0);
            if (a != s + 1) put(a + 1, CLR | BSY);
        end
    endtask

    task automatic play(int n);
        for (int c = 0; c < n; c++) begin
            @(posedge clk);
            #1;
            start = st[c]; k_len = kl[c]; abort = ab[c]; wei_ready = rd[c]; rst_n = rn[c];
            @(negedge clk);
            obs[c] = outv;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outv !== '0) begin errors++; $display("FAIL reset_outputs got=%b exp=%b", outv, 10'h000); end
        @(negedge clk);
        rst_n = 1'b1;
        init();
        play(6);
        for (int c = 0; c < 6; c++) begin
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL reset_idle cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
    endtask

    task automatic test_basic();
        int pen_n;
        init(); go(0, 3); add_tile(0, 3, -1); play(24);
        pen_n = 0;
        for (int c = 0; c < 24; c++) begin
            pen_n += int'(obs[c][2]);
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL basic cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
        checks++;
        if (pen_n != 11) begin errors++; $display("FAIL basic_pen_count got=%0d exp=11", pen_n); end
        checks++;
        if (obs[17][0] !== 1'b1) begin errors++; $display("FAIL basic_done17 got=%b exp=1", obs[17][0]); end
    endtask

    task automatic test_stall();
        int wr_n;
        init(); rd[7] = 1'b0; rd[8] = 1'b0; go(0, 3); add_tile(0, 3, -1); play(26);
        wr_n = 0;
        for (int c = 0; c < 26; c++) begin
            wr_n += int'(obs[c][3]);
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL stall cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
        checks++;
        if (wr_n != 3) begin errors++; $display("FAIL stall_wei_rd_count got=%0d exp=3", wr_n); end
        checks++;
        if (obs[19][0] !== 1'b1) begin errors++; $display("FAIL stall_done19 got=%b exp=1", obs[19][0]); end
    endtask

    task automatic test_k0();
        init(); go(0, 0); add_tile(0, 0, -1); play(8);
        for (int c = 0; c < 8; c++) begin
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL k0 cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
    endtask

    task automatic test_abort();
        int dn_n;
        init(); go(0, 3); ab[12] = 1'b1; add_tile(0, 3, 12); go(14, 3); add_tile(14, 3, -1); play(40);
        dn_n = 0;
        for (int c = 0; c < 40; c++) begin
            dn_n += int'(obs[c][0]);
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL abort cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
        checks++;
        if (dn_n != 1) begin errors++; $display("FAIL abort_done_count got=%0d exp=1", dn_n); end
    endtask

    task automatic test_start_ignored();
        init(); go(0, 3); st[4] = 1'b1; kl[4] = 9; add_tile(0, 3, -1); play(24);
        for (int c = 0; c < 24; c++) begin
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL start_busy cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
    endtask

    task automatic test_rst_mid();
        init(); go(0, 3); add_tile(0, 3, -1); rn[7] = 1'b0;
        for (int c = 7; c < N; c++) ex[c] = '0;
        go(10, 2); add_tile(10, 2, -1); play(30);
        for (int c = 0; c < 30; c++) begin
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL rst_mid cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
    endtask

    task automatic test_back_to_back();
        init(); go(0, 2); add_tile(0, 2, -1); st[16] = 1'b1; kl[16] = 5; go(17, 2); add_tile(17, 2, -1); play(40);
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs[c] !== ex[c]) begin errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", c, obs[c], ex[c]); end
        end
    endtask

    task automatic test_random();
        int k, a;
        for (int it = 0; it < 20; it++) begin
            init();
            k = int'($urandom_range(0, 12));
            for (int c = 0; c < N; c++) rd[c] = ($urandom_range(0, 9) < 7) || c >= 60;
            a = -1;
            if ($urandom_range(0, 3) == 0) begin
                a = int'($urandom_range(1, 30));
                ab[a] = 1'b1;
            end
            go(0, k); add_tile(0, k, a); play(80);
            for (int c = 0; c < 80; c++) begin
                checks++;
                if (obs[c] !== ex[c]) begin
                    errors++;
                    $display("FAIL random it=%0d k=%0d abort=%0d cyc=%0d got=%b exp=%b", it, k, a, c, obs[c], ex[c]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_k0();
        test_abort();
        test_start_ignored();
        test_rst_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
